// File: rtl/led_chain_driver.sv
// Serial driver for a daisy-chain of SIPO latch registers behind the front-panel LEDs.
// Double-buffered frame input, periodic refresh of the held frame, PWM on output enable.
module led_chain_driver #(
   parameter int CHAIN_BITS     = 72,
   parameter int SCLK_DIV_LOG2  = 4,
   parameter int LOAD_CYCLES    = 16,
   parameter int REFRESH_CYCLES = 131072,
   parameter int MSB_FIRST      = 0,
   parameter int BRIGHT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHAIN_BITS-1:0] frame_data,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic                  sclk,
   output logic                  sdata,
   output logic                  sload,
   output logic                  sclr_n,
   output logic                  oe_n,
   output logic                  frame_done
);

   localparam int BIT_W = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;
   localparam int PH_W  = SCLK_DIV_LOG2 + 1;
   localparam int LD_W  = $clog2(LOAD_CYCLES + 1);
   localparam int RF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   localparam logic [BIT_W-1:0]    LAST_BIT = BIT_W'(CHAIN_BITS - 1);
   localparam logic [PH_W-1:0]     LAST_PH  = {PH_W{1'b1}};
   localparam logic [LD_W-1:0]     LAST_LD  = LD_W'(LOAD_CYCLES - 1);
   localparam logic [RF_W-1:0]     LAST_RF  = RF_W'(REFRESH_CYCLES - 1);
   localparam logic [BIT_W-1:0]    ONE_BIT  = BIT_W'(1);
   localparam logic [PH_W-1:0]     ONE_PH   = PH_W'(1);
   localparam logic [LD_W-1:0]     ONE_LD   = LD_W'(1);
   localparam logic [RF_W-1:0]     ONE_RF   = RF_W'(1);
   localparam logic [BRIGHT_W-1:0] ONE_PWM  = BRIGHT_W'(1);

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LATCH = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic                  clr_cnt_r, clr_cnt_s;
   logic [BIT_W-1:0]      bit_idx_r, bit_idx_s;
   logic [PH_W-1:0]       phase_r, phase_s;
   logic [LD_W-1:0]       load_cnt_r, load_cnt_s;
   logic [RF_W-1:0]       refresh_r, refresh_s;
   logic [CHAIN_BITS-1:0] shift_r, shift_s;
   logic [CHAIN_BITS-1:0] pending_r, pending_s;
   logic                  pending_full_r, pending_full_s;
   logic [BRIGHT_W-1:0]   pwm_r, pwm_s;
   logic                  consume_s;
   logic                  accept_s;
   logic [BIT_W-1:0]      bit_pos_s;
   logic [RF_W-1:0]       refresh_inc_s;

   logic sclk_r, sdata_r, sload_r, sclr_n_r, oe_n_r, frame_done_r, frame_ready_r;
   logic sclk_s, sdata_s, sload_s, sclr_n_s, oe_n_s, frame_done_s, frame_ready_s;

   assign frame_ready = frame_ready_r;
   assign sclk        = sclk_r;
   assign sdata       = sdata_r;
   assign sload       = sload_r;
   assign sclr_n      = sclr_n_r;
   assign oe_n        = oe_n_r;
   assign frame_done  = frame_done_r;

   // Next-state sequencing, buffer handoff and the registered-output values derived from it.
   always_comb begin
      state_s        = state_r;
      clr_cnt_s      = clr_cnt_r;
      bit_idx_s      = bit_idx_r;
      phase_s        = phase_r;
      load_cnt_s     = load_cnt_r;
      refresh_s      = refresh_r;
      shift_s        = shift_r;
      pending_s      = pending_r;
      pending_full_s = pending_full_r;
      consume_s      = 1'b0;
      accept_s       = frame_valid & frame_ready_r;
      refresh_inc_s  = (refresh_r == LAST_RF) ? refresh_r : (refresh_r + ONE_RF);

      case (state_r)
         ST_CLEAR: begin
            if (clr_cnt_r) begin
               state_s   = ST_IDLE;
               clr_cnt_s = 1'b0;
            end else begin
               clr_cnt_s = 1'b1;
            end
         end
         ST_IDLE: begin
            if (pending_full_r) begin
               consume_s = 1'b1;
               state_s   = ST_SHIFT;
               refresh_s = '0;
               bit_idx_s = '0;
               phase_s   = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            refresh_s = refresh_inc_s;
            if (phase_r == LAST_PH) begin
               phase_s = '0;
               if (bit_idx_r == LAST_BIT) begin
                  state_s    = ST_LATCH;
                  bit_idx_s  = '0;
                  load_cnt_s = '0;
               end else begin
                  bit_idx_s = bit_idx_r + ONE_BIT;
               end
            end else begin
               phase_s = phase_r + ONE_PH;
            end
         end
         ST_LATCH: begin
            refresh_s = refresh_inc_s;
            if (load_cnt_r == LAST_LD) begin
               state_s    = ST_HOLD;
               load_cnt_s = '0;
            end else begin
               load_cnt_s = load_cnt_r + ONE_LD;
            end
         end
         ST_HOLD: begin
            // Frame period ends here; a waiting frame replaces the retained one.
            if (refresh_r == LAST_RF) begin
               state_s   = ST_SHIFT;
               consume_s = pending_full_r;
               refresh_s = '0;
               bit_idx_s = '0;
               phase_s   = '0;
            end else begin
               refresh_s = refresh_inc_s;
            end
         end
         default: begin
            state_s   = ST_CLEAR;
            clr_cnt_s = 1'b0;
         end
      endcase

      if (accept_s) begin
         pending_s      = frame_data;
         pending_full_s = 1'b1;
      end else if (consume_s) begin
         shift_s        = pending_r;
         pending_full_s = 1'b0;
      end else begin
         pending_full_s = pending_full_r;
      end

      bit_pos_s     = (MSB_FIRST != 0) ? (LAST_BIT - bit_idx_s) : bit_idx_s;
      pwm_s         = pwm_r + ONE_PWM;
      sclk_s        = (state_s == ST_SHIFT) & phase_s[PH_W-1];
      sdata_s       = (state_s == ST_SHIFT) ? shift_s[bit_pos_s] : 1'b0;
      sload_s       = (state_s == ST_LATCH);
      frame_done_s  = (state_s == ST_LATCH) & (load_cnt_s == LAST_LD);
      sclr_n_s      = (state_s != ST_CLEAR);
      frame_ready_s = (state_s != ST_CLEAR) & ~pending_full_s;
      oe_n_s        = ((state_s == ST_CLEAR) || (state_s == ST_IDLE)) ? 1'b1 : ~(pwm_s < brightness);
   end

   // State, counters, buffers and all outputs; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_CLEAR;
         clr_cnt_r      <= 1'b0;
         bit_idx_r      <= '0;
         phase_r        <= '0;
         load_cnt_r     <= '0;
         refresh_r      <= '0;
         shift_r        <= '0;
         pending_r      <= '0;
         pending_full_r <= 1'b0;
         pwm_r          <= '0;
         sclk_r         <= 1'b0;
         sdata_r        <= 1'b0;
         sload_r        <= 1'b0;
         sclr_n_r       <= 1'b0;
         oe_n_r         <= 1'b1;
         frame_done_r   <= 1'b0;
         frame_ready_r  <= 1'b0;
      end else begin
         state_r        <= state_s;
         clr_cnt_r      <= clr_cnt_s;
         bit_idx_r      <= bit_idx_s;
         phase_r        <= phase_s;
         load_cnt_r     <= load_cnt_s;
         refresh_r      <= refresh_s;
         shift_r        <= shift_s;
         pending_r      <= pending_s;
         pending_full_r <= pending_full_s;
         pwm_r          <= pwm_s;
         sclk_r         <= sclk_s;
         sdata_r        <= sdata_s;
         sload_r        <= sload_s;
         sclr_n_r       <= sclr_n_s;
         oe_n_r         <= oe_n_s;
         frame_done_r   <= frame_done_s;
         frame_ready_r  <= frame_ready_s;
      end
   end

endmodule

// File: tb/tb_led_chain_driver.sv
// Bench for led_chain_driver: cycle-timing model plus a queue of expected latched frames.
module tb_led_chain_driver;

   localparam int REF = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] frame_data = 8'h00;
   logic       frame_valid = 1'b0;
   logic [7:0] frame_data_m = 8'h00;
   logic       frame_valid_m = 1'b0;
   logic [3:0] brightness = 4'd0;

   logic frame_ready, sclk, sdata, sload, sclr_n, oe_n, frame_done;
   logic frame_ready_m, sclk_m, sdata_m, sload_m, sclr_n_m, oe_n_m, frame_done_m;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   led_chain_driver #(.CHAIN_BITS(8), .SCLK_DIV_LOG2(1), .LOAD_CYCLES(3), .REFRESH_CYCLES(REF),
                      .MSB_FIRST(0), .BRIGHT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .brightness(brightness), .sclk(sclk), .sdata(sdata),
      .sload(sload), .sclr_n(sclr_n), .oe_n(oe_n), .frame_done(frame_done));

   led_chain_driver #(.CHAIN_BITS(8), .SCLK_DIV_LOG2(1), .LOAD_CYCLES(3), .REFRESH_CYCLES(REF),
                      .MSB_FIRST(1), .BRIGHT_W(4)) dut_m (
      .clk(clk), .rst_n(rst_n), .frame_data(frame_data_m), .frame_valid(frame_valid_m),
      .frame_ready(frame_ready_m), .brightness(brightness), .sclk(sclk_m), .sdata(sdata_m),
      .sload(sload_m), .sclr_n(sclr_n_m), .oe_n(oe_n_m), .frame_done(frame_done_m));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model of the LSB-first instance, advanced on each clock edge.
   int         cyc, cur_start, next_start, clr_e;
   logic       full_m, started, ready_exp, sclr_exp, oe_exp;
   logic [7:0] pend_m, cur_m;
   logic [3:0] pwm_m;
   logic [7:0] exp_q[$];

   always @(posedge clk or negedge rst_n) begin : model
      int t, clr_n;
      logic st, acc, full_n, started_n;
      logic [3:0] pwm_n;
      if (!rst_n) begin
         cyc <= 0; cur_start <= 0; next_start <= 0; clr_e <= 0;
         full_m <= 1'b0; started <= 1'b0; pend_m <= 8'h00; cur_m <= 8'h00; pwm_m <= 4'd0;
         ready_exp <= 1'b0; sclr_exp <= 1'b0; oe_exp <= 1'b1;
         exp_q.delete();
      end else begin
         t         = cyc + 1;
         st        = started ? (t == next_start) : (clr_e >= 2 && full_m);
         acc       = frame_valid && !full_m && clr_e >= 2;
         full_n    = acc ? 1'b1 : (st ? 1'b0 : full_m);
         clr_n     = (clr_e < 2) ? clr_e + 1 : 2;
         started_n = started | st;
         pwm_n     = pwm_m + 4'd1;
         cyc <= t; clr_e <= clr_n; full_m <= full_n; started <= started_n; pwm_m <= pwm_n;
         if (acc) pend_m <= frame_data;
         if (st) begin
            cur_start  <= t;
            next_start <= t + REF;
            if (full_m) begin
               cur_m <= pend_m;
               exp_q.push_back(pend_m);
            end else begin
               exp_q.push_back(cur_m);
            end
         end
         ready_exp <= (clr_n >= 2) && !full_n;
         sclr_exp  <= (clr_n >= 2);
         oe_exp    <= started_n ? !(pwm_n < brightness) : 1'b1;
      end
   end

   // Per-cycle compare against the model, plus a chain model checked at each latch strobe.
   logic       prev_sclk, prev_sload;
   logic [7:0] chain;
   int         rises, n_latch;
   always @(negedge clk) begin : mon
      int rel;
      logic in_frame;
      if (!rst_n) begin
         prev_sclk = 1'b0; prev_sload = 1'b0; chain = 8'h00; rises = 0;
      end else begin
         rel      = cyc - cur_start;
         in_frame = started && rel >= 0 && rel < 32;
         chk("sclk", sclk, in_frame && (rel % 4) >= 2);
         chk("sdata", sdata, in_frame ? cur_m[rel / 4] : 1'b0);
         chk("sload", sload, started && rel >= 32 && rel < 35);
         chk("frame_done", frame_done, started && rel == 34);
         chk("frame_ready", frame_ready, ready_exp);
         chk("sclr_n", sclr_n, sclr_exp);
         chk("oe_n", oe_n, oe_exp);
         if (sclk && !prev_sclk) begin
            chain = {sdata, chain[7:1]};
            rises++;
         end
         if (sload && !prev_sload) begin
            n_latch++;
            chk("rises_per_frame", rises, 8);
            rises = 0;
            if (exp_q.size() == 0) chk("expected_frame_queued", 0, 1);
            else chk("latched_frame", chain, exp_q.pop_front());
         end
         prev_sclk  = sclk;
         prev_sload = sload;
      end
   end

   // MSB-first instance: bit order on the wire and the latched result.
   logic       prev_sclk_m, prev_sload_m, exp_m_valid;
   logic [7:0] chain_m, exp_m;
   int         rises_m, n_latch_m;
   always @(negedge clk) begin : mon_m
      if (!rst_n) begin
         prev_sclk_m = 1'b0; prev_sload_m = 1'b0; chain_m = 8'h00; rises_m = 0;
      end else begin
         if (sclk_m && !prev_sclk_m) begin
            if (exp_m_valid && rises_m < 8) chk("msb_sdata", sdata_m, exp_m[7 - rises_m]);
            chain_m = {chain_m[6:0], sdata_m};
            rises_m++;
         end
         if (sload_m && !prev_sload_m) begin
            n_latch_m++;
            chk("msb_rises", rises_m, 8);
            chk("msb_latched", chain_m, exp_m);
            rises_m = 0;
         end
         prev_sclk_m  = sclk_m;
         prev_sload_m = sload_m;
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_sclk"}, sclk, 1'b0);
      chk({tag, "_sdata"}, sdata, 1'b0);
      chk({tag, "_sload"}, sload, 1'b0);
      chk({tag, "_sclr_n"}, sclr_n, 1'b0);
      chk({tag, "_oe_n"}, oe_n, 1'b1);
      chk({tag, "_ready"}, frame_ready, 1'b0);
      chk({tag, "_done"}, frame_done, 1'b0);
      chk({tag, "_m_sclr_n"}, sclr_n_m, 1'b0);
      chk({tag, "_m_oe_n"}, oe_n_m, 1'b1);
   endtask

   task automatic send(input logic [7:0] d);
      int w = 0;
      frame_data  = d;
      frame_valid = 1'b1;
      while (!frame_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("send_accept_in_time", w < 300, 1'b1);
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   task automatic wait_sclk_high();
      int w = 0;
      while (!sclk && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("sclk_seen_in_time", w < 200, 1'b1);
   endtask

   initial begin
      int low;
      logic [3:0] levels [3];
      levels = '{4'd5, 4'd15, 4'd0};
      n_latch = 0; n_latch_m = 0; exp_m_valid = 1'b0; exp_m = 8'h00;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("clear_cycle1_sclr_n", sclr_n, 1'b0);
      @(negedge clk);
      chk("clear_done_sclr_n", sclr_n, 1'b1);
      chk("clear_done_ready", frame_ready, 1'b1);
      chk("idle_oe_n", oe_n, 1'b1);
      repeat (3) @(negedge clk);
      chk("idle_no_sclk", sclk, 1'b0);

      exp_m = 8'h01; exp_m_valid = 1'b1;
      frame_data_m = 8'h01; frame_valid_m = 1'b1;
      @(negedge clk);
      frame_valid_m = 1'b0;

      send(8'hA5);
      repeat (150) @(negedge clk);

      wait_sclk_high();
      send(8'h3C);
      send(8'hFF);
      repeat (200) @(negedge clk);

      foreach (levels[i]) begin
         brightness = levels[i];
         low = 0;
         for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!oe_n) low++;
         end
         chk("pwm_low_count", low, levels[i]);
      end

      chk("frames_latched", n_latch >= 6, 1'b1);
      chk("msb_frames_latched", n_latch_m >= 1, 1'b1);

      wait_sclk_high();
      rst_n = 1'b0;
      exp_m_valid = 1'b0;
      #1;
      check_reset("midshift_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reclear_cycle1_sclr_n", sclr_n, 1'b0);
      @(negedge clk);
      chk("reclear_done_sclr_n", sclr_n, 1'b1);
      chk("reclear_ready", frame_ready, 1'b1);
      repeat (40) @(negedge clk);
      chk("no_load_after_reset", sload, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
